ted_symbol_sched: RTL and testbench

TED_SYMBOL_SCHED -- requirements
Module: ted_symbol_sched

---
 rtl/msk_timing_pkg.sv | 17 +
 rtl/ted_lock_det.sv | 89 ++++++++
 rtl/ted_symbol_sched.sv | 134 +++++++++++++
 tb/tb_ted_symbol_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_timing_pkg.sv
// Shared timing-recovery types and default parameter values.
package msk_timing_pkg;

  localparam int unsigned OSF_DEF         = 20;
  localparam int unsigned MID_DEF         = 10;
  localparam int unsigned ERR_W_DEF       = 32;
  localparam int unsigned LOCK_THRESH_DEF = 1000;
  localparam int unsigned LOCK_CNT_DEF    = 16;
  localparam int unsigned UNLOCK_CNT_DEF  = 4;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/ted_lock_det.sv
// Lock detector: counts consecutive good/bad timing-error samples.
module ted_lock_det
  import msk_timing_pkg::*;
#(
  parameter int unsigned ERR_W       = ERR_W_DEF,
  parameter int unsigned LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT  = UNLOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err_valid,
  input  logic [ERR_W-1:0] err,
  output logic [1:0]       lock_state,
  output logic             locked
);

  localparam int unsigned G_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned B_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  lock_state_t      state_q;
  logic [G_W-1:0]   good_q;
  logic [B_W-1:0]   bad_q;
  logic             locked_q;
  logic [ERR_W-1:0] err_mag;
  logic             is_good;

  // Saturating magnitude: the most negative code maps to the most positive.
  always_comb begin
    err_mag = err;
    if (err == ERR_MIN) begin
      err_mag = ERR_MAX;
    end else if (err[ERR_W-1]) begin
      err_mag = ~err + ERR_W'(1);
    end
    is_good = (err_mag <= ERR_W'(LOCK_THRESH));
  end

  // Lock state machine, advanced once per err_valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ACQ;
      good_q   <= '0;
      bad_q    <= '0;
      locked_q <= 1'b0;
    end else if (err_valid) begin
      case (state_q)
        ACQ, TRACK: begin
          if (!is_good) begin
            state_q <= TRACK;
            good_q  <= '0;
          end else if (good_q == G_W'(LOCK_CNT - 1)) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            good_q   <= '0;
            bad_q    <= '0;
          end else begin
            state_q <= TRACK;
            good_q  <= good_q + G_W'(1);
          end
        end
        LOCKED: begin
          if (is_good) begin
            bad_q <= '0;
          end else if (bad_q == B_W'(UNLOCK_CNT - 1)) begin
            state_q  <= TRACK;
            locked_q <= 1'b0;
            good_q   <= '0;
            bad_q    <= '0;
          end else begin
            bad_q <= bad_q + B_W'(1);
          end
        end
        default: begin
          state_q  <= ACQ;
          locked_q <= 1'b0;
          good_q   <= '0;
          bad_q    <= '0;
        end
      endcase
    end
  end

  assign lock_state = state_q;
  assign locked     = locked_q;

endmodule

// File: rtl/ted_symbol_sched.sv
// Symbol timing scheduler: sample phase counter, TED strobes, phase adjust and lock status.
module ted_symbol_sched
  import msk_timing_pkg::*;
#(
  parameter int unsigned OSF         = OSF_DEF,
  parameter int unsigned MID         = MID_DEF,
  parameter int unsigned ERR_W       = ERR_W_DEF,
  parameter int unsigned LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
  parameter int unsigned UNLOCK_CNT  = UNLOCK_CNT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic                    err_valid,
  input  logic [ERR_W-1:0]        err,
  input  logic                    adj_req,
  input  logic                    adj_dir,
  output logic                    adj_ack,
  output logic                    early_stb,
  output logic                    mid_stb,
  output logic                    late_stb,
  output logic                    sym_stb,
  output logic [$clog2(OSF)-1:0]  phase,
  output logic [1:0]              lock_state,
  output logic                    locked
);

  localparam int unsigned PH_W = $clog2(OSF);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSF - 1);
  localparam logic [PH_W-1:0] PH_EARLY = PH_W'(MID - 1);
  localparam logic [PH_W-1:0] PH_MID   = PH_W'(MID);
  localparam logic [PH_W-1:0] PH_LATE  = PH_W'(MID + 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            pending_q, pending_d;
  logic            dir_q, dir_d;
  logic            hold_q, hold_d;
  logic            early_q, early_d;
  logic            mid_q, mid_d;
  logic            late_q, late_d;
  logic            sym_q, sym_d;
  logic            ack_q, ack_d;

  // Next phase, strobe decode and adjust handshake.
  always_comb begin
    phase_d   = phase_q;
    pending_d = pending_q;
    dir_d     = dir_q;
    hold_d    = hold_q;
    early_d   = 1'b0;
    mid_d     = 1'b0;
    late_d    = 1'b0;
    sym_d     = 1'b0;
    ack_d     = 1'b0;

    if (sample_valid) begin
      early_d = (phase_q == PH_EARLY);
      mid_d   = (phase_q == PH_MID);
      late_d  = (phase_q == PH_LATE);
      if (phase_q != PH_LAST) begin
        phase_d = phase_q + PH_W'(1);
      end else if (hold_q) begin
        // second sample at the last index of a retarded symbol
        sym_d   = 1'b1;
        phase_d = '0;
        hold_d  = 1'b0;
      end else if (pending_q && !dir_q) begin
        // retard: repeat the last index once more
        hold_d    = 1'b1;
        pending_d = 1'b0;
      end else begin
        sym_d   = 1'b1;
        phase_d = (pending_q && dir_q) ? PH_W'(1) : '0;
        if (pending_q) begin
          pending_d = 1'b0;
        end
      end
    end

    if (adj_req && !pending_q) begin
      pending_d = 1'b1;
      dir_d     = adj_dir;
      ack_d     = 1'b1;
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= '0;
      pending_q <= 1'b0;
      dir_q     <= 1'b0;
      hold_q    <= 1'b0;
      early_q   <= 1'b0;
      mid_q     <= 1'b0;
      late_q    <= 1'b0;
      sym_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      hold_q    <= hold_d;
      early_q   <= early_d;
      mid_q     <= mid_d;
      late_q    <= late_d;
      sym_q     <= sym_d;
      ack_q     <= ack_d;
    end
  end

  assign phase     = phase_q;
  assign early_stb = early_q;
  assign mid_stb   = mid_q;
  assign late_stb  = late_q;
  assign sym_stb   = sym_q;
  assign adj_ack   = ack_q;

  ted_lock_det #(
    .ERR_W       (ERR_W),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_CNT  (UNLOCK_CNT)
  ) u_lock_det (
    .clk        (clk),
    .reset      (reset),
    .err_valid  (err_valid),
    .err        (err),
    .lock_state (lock_state),
    .locked     (locked)
  );

endmodule

// File: tb/tb_ted_symbol_sched.sv
// Scoreboard bench for ted_symbol_sched against a symbol-sequence reference model.
module tb_ted_symbol_sched;

  localparam int OSF  = 20;
  localparam int MID  = 10;
  localparam int THR  = 1000;
  localparam int LCNT = 16;
  localparam int UCNT = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_valid, err_valid, adj_req, adj_dir;
  logic signed [31:0] err;
  logic               adj_ack, early_stb, mid_stb, late_stb, sym_stb, locked;
  logic [4:0]         phase;
  logic [1:0]         lock_state;

  ted_symbol_sched dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .err_valid(err_valid),
    .err(err), .adj_req(adj_req), .adj_dir(adj_dir), .adj_ack(adj_ack),
    .early_stb(early_stb), .mid_stb(mid_stb), .late_stb(late_stb), .sym_stb(sym_stb),
    .phase(phase), .lock_state(lock_state), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { int c; bit e; bit m; bit l; bit s; } stb_t;
  typedef struct { int c; int v; } val_t;
  stb_t sq[$];
  val_t pq[$];
  val_t lq[$];
  int   aq[$];

  // reference model: indices still to be visited in the current symbol
  int seq[$];
  bit m_pend, m_dir, m_ext, m_cap;
  int m_state, m_good, m_bad;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    seq.delete();
    for (int i = 0; i < OSF; i++) seq.push_back(i);
    m_pend = 0; m_dir = 0; m_ext = 0;
    m_state = 0; m_good = 0; m_bad = 0;
  endtask

  // drive one cycle of inputs and record what the DUT must show after the next edge
  task automatic cycle(input bit sv, input bit rq, input bit dr, input bit ev,
                       input logic signed [31:0] e);
    int c, k, start;
    bit last, pb, good;
    longint le, mag;
    stb_t s;
    sample_valid = sv; adj_req = rq; adj_dir = dr; err_valid = ev; err = e;
    c = cyc + 1;
    pb = m_pend;
    m_cap = 0;
    if (sv) begin
      k = seq.pop_front();
      last = (seq.size() == 0);
      s.c = c; s.e = (k == MID - 1); s.m = (k == MID); s.l = (k == MID + 1); s.s = 0;
      if (last) begin
        if (!m_ext && pb && !m_dir) begin
          seq.push_back(OSF - 1);
          m_ext = 1; m_pend = 0;
        end else begin
          s.s = 1;
          start = (!m_ext && pb && m_dir) ? 1 : 0;
          if (start == 1) m_pend = 0;
          m_ext = 0;
          for (int i = start; i < OSF; i++) seq.push_back(i);
        end
      end
      if (s.e || s.m || s.l || s.s) sq.push_back(s);
      pq.push_back('{c, seq[0]});
    end
    if (rq && !pb) begin
      m_pend = 1; m_dir = dr; m_cap = 1;
      aq.push_back(c);
    end
    if (ev) begin
      le = e;
      if (le == -64'sd2147483648) mag = 64'sd2147483647;
      else mag = (le < 0) ? -le : le;
      good = (mag <= THR);
      if (m_state == 2) begin
        if (good) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad == UCNT) begin m_state = 1; m_good = 0; m_bad = 0; end
        end
      end else begin
        m_state = 1;
        if (good) begin
          m_good++;
          if (m_good == LCNT) begin m_state = 2; m_good = 0; end
        end else m_good = 0;
      end
      lq.push_back('{c, m_state});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 0; adj_req = 0; adj_dir = 0; err_valid = 0; err = '0;
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_strobes", int'({early_stb, mid_stb, late_stb, sym_stb}), 0);
    check("rst_adj_ack", int'(adj_ack), 0);
    check("rst_lock_state", int'(lock_state), 0);
    check("rst_locked", int'(locked), 0);
    sq.delete(); pq.delete(); lq.delete(); aq.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: pops expected events when the DUT presents them
  int exp_phase = 0;
  int exp_lock = 0;
  always @(negedge clk) begin
    if (reset) begin
      exp_phase = 0;
      exp_lock = 0;
    end else begin
      while (sq.size() > 0 && sq[0].c < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL strobe_missing: got no strobe, expected e/m/l/s=%b%b%b%b at cycle %0d",
                 sq[0].e, sq[0].m, sq[0].l, sq[0].s, sq[0].c);
        void'(sq.pop_front());
      end
      if (early_stb || mid_stb || late_stb || sym_stb) begin
        n_chk++;
        if (sq.size() == 0 || sq[0].c != cyc) begin
          n_fail++;
          $display("FAIL strobe_unexpected: got e/m/l/s=%b%b%b%b at cycle %0d, expected none",
                   early_stb, mid_stb, late_stb, sym_stb, cyc);
        end else begin
          if ({early_stb, mid_stb, late_stb, sym_stb} != {sq[0].e, sq[0].m, sq[0].l, sq[0].s}) begin
            n_fail++;
            $display("FAIL strobe_value: got e/m/l/s=%b%b%b%b expected %b%b%b%b at cycle %0d",
                     early_stb, mid_stb, late_stb, sym_stb, sq[0].e, sq[0].m, sq[0].l, sq[0].s, cyc);
          end
          void'(sq.pop_front());
        end
      end
      while (aq.size() > 0 && aq[0] < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL adj_ack_missing: got 0, expected ack at cycle %0d", aq[0]);
        void'(aq.pop_front());
      end
      if (adj_ack) begin
        n_chk++;
        if (aq.size() == 0 || aq[0] != cyc) begin
          n_fail++;
          $display("FAIL adj_ack_unexpected: got 1 at cycle %0d, expected 0", cyc);
        end else void'(aq.pop_front());
      end
      while (pq.size() > 0 && pq[0].c <= cyc) begin
        exp_phase = pq[0].v;
        void'(pq.pop_front());
      end
      check("phase", int'(phase), exp_phase);
      while (lq.size() > 0 && lq[0].c <= cyc) begin
        exp_lock = lq[0].v;
        void'(lq.pop_front());
      end
      check("lock_state", int'(lock_state), exp_lock);
      check("locked", int'(locked), (exp_lock == 2) ? 1 : 0);
    end
  end

  int gval[5];
  int bval[5];

  initial begin
    bit req_on, req_dir, ev, sv;
    logic signed [31:0] e;
    gval = '{0, 500, -1000, 1000, -7};
    bval = '{1001, -1001, 5000, 32'h7fffffff, 32'h80000000};
    model_reset();
    reset = 1'b1;
    sample_valid = 0; adj_req = 0; adj_dir = 0; err_valid = 0; err = '0;
    repeat (2) @(posedge clk);
    #1;
    check("init_phase", int'(phase), 0);
    check("init_strobes", int'({early_stb, mid_stb, late_stb, sym_stb, adj_ack}), 0);
    check("init_lock", int'({lock_state, locked}), 0);
    reset = 1'b0;

    // continuous samples plus lock acquire / release sequence
    for (int i = 0; i < 16; i++) begin cycle(1, 0, 0, 1, 500); cycle(1, 0, 0, 0, 0); end
    for (int i = 0; i < 3; i++) begin cycle(1, 0, 0, 1, -2000); cycle(1, 0, 0, 0, 0); end
    cycle(1, 0, 0, 1, 0); cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin cycle(1, 0, 0, 1, 5000); cycle(1, 0, 0, 0, 0); end
    for (int i = 0; i < 16; i++) begin cycle(1, 0, 0, 1, 500); cycle(1, 0, 0, 0, 0); end
    for (int i = 0; i < 4; i++) begin cycle(1, 0, 0, 1, 32'sh80000000); cycle(1, 0, 0, 0, 0); end
    repeat (20) cycle(1, 0, 0, 0, 0);

    // advance requested at phase 5
    for (int i = 0; i < 40 && seq[0] != 5; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    repeat (50) cycle(1, 0, 0, 0, 0);

    // retard requested on the wrap cycle, then a second request while pending
    for (int i = 0; i < 40 && !(seq.size() == 1 && !m_ext && !m_pend); i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 0, 0);
    repeat (60) cycle(1, 0, 0, 0, 0);

    // gapped samples, one valid in three cycles
    for (int i = 0; i < 90; i++) cycle((i % 3) == 0, 0, 0, 0, 0);

    // reset at phase 12 with an advance pending
    for (int i = 0; i < 40 && seq[0] != 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    for (int i = 0; i < 40 && seq[0] != 12; i++) cycle(1, 0, 0, 0, 0);
    check("pre_reset_phase", int'(phase), 12);
    do_reset();
    repeat (45) cycle(1, 0, 0, 0, 0);

    // randomized traffic
    req_on = 0; req_dir = 0;
    for (int i = 0; i < 3000; i++) begin
      sv = ($urandom_range(0, 3) != 0);
      if (!req_on && $urandom_range(0, 39) == 0) begin
        req_on = 1;
        req_dir = 1'($urandom_range(0, 1));
      end
      ev = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 7) e = gval[$urandom_range(0, 4)];
      else e = bval[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0) e = $signed(32'($urandom_range(0, 2000))) - 1000;
      cycle(sv, req_on, req_dir, ev, e);
      if (m_cap) req_on = 0;
    end

    repeat (5) cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check("leftover_strobes", sq.size(), 0);
    check("leftover_acks", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
